// File: rtl/sha_round_state.sv
// SHA-2 compression-state engine: holds working variables a..h and runs ROUNDS rounds per block.
// Optional SHA_ROUND_FEEDFORWARD_EN adds the initial-hash register so state_out carries the chained digest.
`timescale 1ns/1ps
module sha_round_state #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [8*WORD_W-1:0] h_in,
    input  logic [WORD_W-1:0]   w_in,
    input  logic [WORD_W-1:0]   k_in,
    output logic [CNT_W-1:0]    round_idx,
    output logic                busy,
    output logic                done,
    output logic [8*WORD_W-1:0] state_out
);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("sha_round_state: WORD_W must be 32 or 64");
    end
    if (2 ** CNT_W <= ROUNDS) begin : g_bad_cnt_w
        $error("sha_round_state: CNT_W too narrow for ROUNDS");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] big_s0(input logic [WORD_W-1:0] x);
        if (WORD_W == 64) return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
        else              return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] big_s1(input logic [WORD_W-1:0] x);
        if (WORD_W == 64) return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
        else              return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e, f, g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a, b, c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Word 7 is a (MSBs), word 0 is h, matching the h_in/state_out packing.
    state_t                 fsm_q, fsm_d;
    logic [7:0][WORD_W-1:0] wv_q, wv_d;
    logic [7:0][WORD_W-1:0] sout_q, sout_d;
    logic [CNT_W-1:0]       round_q, round_d;
    logic [7:0][WORD_W-1:0] rnd_next;
    logic [7:0][WORD_W-1:0] result;
    logic [WORD_W-1:0]      t1;
    logic [WORD_W-1:0]      t2;
`ifdef SHA_ROUND_FEEDFORWARD_EN
    logic [7:0][WORD_W-1:0] hreg_q, hreg_d;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        wv_d    = wv_q;
        sout_d  = sout_q;
        round_d = round_q;
`ifdef SHA_ROUND_FEEDFORWARD_EN
        hreg_d  = hreg_q;
`endif

        t1 = wv_q[0] + big_s1(wv_q[3]) + ch(wv_q[3], wv_q[2], wv_q[1]) + k_in + w_in;
        t2 = big_s0(wv_q[7]) + maj(wv_q[7], wv_q[6], wv_q[5]);
        rnd_next = {t1 + t2, wv_q[7], wv_q[6], wv_q[5], wv_q[4] + t1, wv_q[3], wv_q[2], wv_q[1]};

        // The result is registered on the last-round edge so it is valid alongside done in FIN.
`ifdef SHA_ROUND_FEEDFORWARD_EN
        for (int i = 0; i < 8; i++) begin
            result[i] = rnd_next[i] + hreg_q[i];
        end
`else
        result = rnd_next;
`endif

        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    fsm_d   = S_RUN;
                    wv_d    = h_in;
                    round_d = '0;
`ifdef SHA_ROUND_FEEDFORWARD_EN
                    hreg_d  = h_in;
`endif
                end
            end
            S_RUN: begin
                wv_d = rnd_next;
                if (round_q == LAST_ROUND) begin
                    fsm_d  = S_FIN;
                    sout_d = result;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            S_FIN: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= S_IDLE;
            wv_q    <= '0;
            sout_q  <= '0;
            round_q <= '0;
`ifdef SHA_ROUND_FEEDFORWARD_EN
            hreg_q  <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            wv_q    <= wv_d;
            sout_q  <= sout_d;
            round_q <= round_d;
`ifdef SHA_ROUND_FEEDFORWARD_EN
            hreg_q  <= hreg_d;
`endif
        end
    end

    assign round_idx = round_q;
    assign busy      = (fsm_q != S_IDLE);
    assign done      = (fsm_q == S_FIN);
    assign state_out = sout_q;

endmodule

// File: tb/tb_sha_round_state.sv
// Bench for sha_round_state: a SHA-256 and a SHA-512 instance checked every cycle against a block-level reference model.
`timescale 1ns/1ps
module tb_sha_round_state;

    localparam int R32 = 64;
    localparam int R64 = 80;

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] D256 = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [63:0] D512_W0 = 64'hddaf35a193617aba;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [1:0]   start_v;
    logic [63:0]  cur_w [2][80];
    logic [63:0]  cur_k [2][80];
    logic [511:0] cur_h [2];

    logic [6:0]   ridx32, ridx64;
    logic         busy32, busy64, done32, done64;
    logic [255:0] sout32;
    logic [511:0] sout64;
    logic [255:0] h32;
    logic [31:0]  w32, k32;
    logic [63:0]  w64, k64;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    assign h32 = cur_h[0][255:0];

    always_comb begin
        w32 = '0;
        k32 = '0;
        w64 = '0;
        k64 = '0;
        if (int'(ridx32) < 80) begin
            w32 = cur_w[0][int'(ridx32)][31:0];
            k32 = cur_k[0][int'(ridx32)][31:0];
        end
        if (int'(ridx64) < 80) begin
            w64 = cur_w[1][int'(ridx64)];
            k64 = cur_k[1][int'(ridx64)];
        end
    end

    sha_round_state #(.WORD_W(32), .ROUNDS(R32), .CNT_W(7)) dut32 (
        .clk(clk), .reset(reset), .start(start_v[0]), .h_in(h32), .w_in(w32), .k_in(k32),
        .round_idx(ridx32), .busy(busy32), .done(done32), .state_out(sout32));

    sha_round_state #(.WORD_W(64), .ROUNDS(R64), .CNT_W(7)) dut64 (
        .clk(clk), .reset(reset), .start(start_v[1]), .h_in(cur_h[1]), .w_in(w64), .k_in(k64),
        .round_idx(ridx64), .busy(busy64), .done(done64), .state_out(sout64));

    function automatic bit lane_done(input int l);
        return (l != 0) ? done64 : done32;
    endfunction
    function automatic bit lane_busy(input int l);
        return (l != 0) ? busy64 : busy32;
    endfunction
    function automatic int lane_idx(input int l);
        return (l != 0) ? int'(ridx64) : int'(ridx32);
    endfunction
    function automatic logic [511:0] lane_out(input int l);
        return (l != 0) ? sout64 : {256'b0, sout32};
    endfunction

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] msk(input int w);
        return (w == 64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    endfunction
    function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int w);
        return ((x >> n) | (x << (w - n))) & msk(w);
    endfunction

    // Full block: ROUNDS rounds of the SHA-2 compression function on cur_h/cur_w/cur_k of lane l.
    function automatic logic [511:0] model_run(input int l);
        int w  = (l != 0) ? 64 : 32;
        int rn = (l != 0) ? R64 : R32;
        logic [63:0] m = msk(w);
        logic [63:0] v [8];
        logic [63:0] hw [8];
        logic [63:0] s0, s1, chv, mj, t1, t2, word;
        logic [511:0] o;
        for (int i = 0; i < 8; i++) begin
            hw[i] = (cur_h[l] >> ((7 - i) * w)) & {448'b0, m};
            v[i]  = hw[i];
        end
        for (int r = 0; r < rn; r++) begin
            if (w == 64) begin
                s1 = rr(v[4], 14, w) ^ rr(v[4], 18, w) ^ rr(v[4], 41, w);
                s0 = rr(v[0], 28, w) ^ rr(v[0], 34, w) ^ rr(v[0], 39, w);
            end else begin
                s1 = rr(v[4], 6, w) ^ rr(v[4], 11, w) ^ rr(v[4], 25, w);
                s0 = rr(v[0], 2, w) ^ rr(v[0], 13, w) ^ rr(v[0], 22, w);
            end
            chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
            mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t1  = (v[7] + s1 + chv + cur_k[l][r] + cur_w[l][r]) & m;
            t2  = (s0 + mj) & m;
            for (int i = 7; i > 0; i--) v[i] = v[i - 1];
            v[4] = (v[4] + t1) & m;
            v[0] = (t1 + t2) & m;
        end
        o = '0;
        for (int i = 0; i < 8; i++) begin
`ifdef SHA_ROUND_FEEDFORWARD_EN
            word = (v[i] + hw[i]) & m;
`else
            word = v[i];
`endif
            o = o | ({448'b0, word} << ((7 - i) * w));
        end
        return o;
    endfunction

    task automatic load_abc(input int l);
        int w  = (l != 0) ? 64 : 32;
        int rn = (l != 0) ? R64 : R32;
        logic [63:0] m = msk(w);
        logic [63:0] x, y, s0, s1;
        for (int t = 0; t < 80; t++) begin
            cur_w[l][t] = '0;
            cur_k[l][t] = (l != 0) ? K512[t] : {32'b0, K512[t][63:32]};
        end
        cur_w[l][0]  = (l != 0) ? 64'h6162638000000000 : 64'h0000000061626380;
        cur_w[l][15] = 64'd24;
        for (int t = 16; t < rn; t++) begin
            x = cur_w[l][t - 15];
            y = cur_w[l][t - 2];
            if (l != 0) begin
                s0 = rr(x, 1, w) ^ rr(x, 8, w) ^ (x >> 7);
                s1 = rr(y, 19, w) ^ rr(y, 61, w) ^ (y >> 6);
            end else begin
                s0 = rr(x, 7, w) ^ rr(x, 18, w) ^ (x >> 3);
                s1 = rr(y, 17, w) ^ rr(y, 19, w) ^ (y >> 10);
            end
            cur_w[l][t] = (s1 + cur_w[l][t - 7] + s0 + cur_w[l][t - 16]) & m;
        end
        cur_h[l] = (l != 0) ? IV512 : {256'b0, IV256};
    endtask

    task automatic load_random(input int l);
        for (int t = 0; t < 80; t++) begin
            cur_w[l][t] = (l != 0) ? {$urandom, $urandom} : {32'b0, $urandom};
            cur_k[l][t] = (l != 0) ? {$urandom, $urandom} : {32'b0, $urandom};
        end
        cur_h[l] = '0;
        for (int i = 0; i < ((l != 0) ? 16 : 8); i++) cur_h[l][i * 32 +: 32] = $urandom;
    endtask

    // Cycle-level expectation per lane: cycles elapsed since the accepted start.
    int           m_pos [2];
    int           m_idx [2];
    logic [511:0] m_out [2];
    logic [511:0] m_res [2];

    initial begin
        m_pos = '{0, 0};
        m_idx = '{0, 0};
    end

    always @(posedge clk) begin
        int rn;
        for (int l = 0; l < 2; l++) begin
            rn = (l != 0) ? R64 : R32;
            if (reset) begin
                m_pos[l] <= 0;
                m_idx[l] <= 0;
                m_out[l] <= '0;
            end else if (m_pos[l] == 0) begin
                if (start_v[l]) begin
                    m_pos[l] <= 1;
                    m_idx[l] <= 0;
                    m_res[l] <= model_run(l);
                end
            end else if (m_pos[l] + 1 <= rn) begin
                m_pos[l] <= m_pos[l] + 1;
                m_idx[l] <= m_pos[l];
            end else if (m_pos[l] + 1 == rn + 1) begin
                m_pos[l] <= rn + 1;
                m_out[l] <= m_res[l];
            end else begin
                m_pos[l] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        int rn;
        if (cmp_en) begin
            for (int l = 0; l < 2; l++) begin
                rn = (l != 0) ? R64 : R32;
                chk($sformatf("busy[%0d]", l), 512'(lane_busy(l)), 512'(m_pos[l] != 0));
                chk($sformatf("done[%0d]", l), 512'(lane_done(l)), 512'(m_pos[l] == rn + 1));
                chk($sformatf("round_idx[%0d]", l), 512'(lane_idx(l)), 512'(m_idx[l]));
                chk($sformatf("state_out[%0d]", l), lane_out(l), m_out[l]);
            end
        end
    end

    // Starts a block from an idle negedge; returns at the idle cycle after FIN.
    task automatic run_block(input int l, input bit perturb, output int lat);
        start_v[l] = 1'b1;
        @(negedge clk);
        start_v[l] = 1'b0;
        lat = 1;
        while (!lane_done(l) && lat < 200) begin
            start_v[l] = perturb && (lane_idx(l) == 10);
            @(negedge clk);
            lat++;
        end
        start_v[l] = perturb;
        @(negedge clk);
    endtask

    logic [255:0] exp256;
    logic [63:0]  exp512_w0;
    int lat;
    int n;

    initial begin
        reset   = 1'b1;
        start_v = 2'b11;
        for (int l = 0; l < 2; l++) begin
            cur_h[l] = '0;
            for (int t = 0; t < 80; t++) begin
                cur_w[l][t] = '0;
                cur_k[l][t] = '0;
            end
        end
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy32", 512'(busy32), 512'(0));
        chk("reset_done64", 512'(done64), 512'(0));
        chk("reset_out32", {256'b0, sout32}, 512'(0));
        chk("reset_idx64", 512'(ridx64), 512'(0));
        reset   = 1'b0;
        start_v = 2'b00;
        @(negedge clk);

`ifdef SHA_ROUND_FEEDFORWARD_EN
        exp256    = D256;
        exp512_w0 = D512_W0;
`else
        for (int i = 0; i < 8; i++) exp256[i * 32 +: 32] = D256[i * 32 +: 32] - IV256[i * 32 +: 32];
        exp512_w0 = D512_W0 - 64'h6a09e667f3bcc908;
`endif

        // SHA-256 "abc" with starts during round 10 and during FIN, then a back-to-back start.
        load_abc(0);
        chk("model_abc256", model_run(0), {256'b0, exp256});
        run_block(0, 1'b1, lat);
        chk("abc256_latency", 512'(lat), 512'(R32 + 1));
        chk("abc256_digest", {256'b0, sout32}, {256'b0, exp256});
`ifdef SHA_ROUND_FEEDFORWARD_EN
        chk("abc256_word0", 512'(sout32[255:224]), 512'(32'hba7816bf));
`else
        chk("abc256_word0", 512'(sout32[255:224]), 512'(32'h506e3058));
`endif
        chk("idle_at_rounds_plus2", 512'(busy32), 512'(0));
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("b2b_round_idx", 512'(ridx32), 512'(0));
        chk("b2b_busy", 512'(busy32), 512'(1));
        n = 1;
        while (!done32 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_latency", 512'(n), 512'(R32 + 1));
        chk("b2b_digest", {256'b0, sout32}, {256'b0, exp256});
        @(negedge clk);

        // Reset while round_idx is 30 abandons the block.
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        while (ridx32 != 7'd30 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_round30", 512'(ridx32), 512'(30));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_busy", 512'(busy32), 512'(0));
        chk("midreset_out", {256'b0, sout32}, 512'(0));
        for (int i = 0; i < 70; i++) begin
            chk("midreset_no_done", 512'(done32), 512'(0));
            @(negedge clk);
        end
        run_block(0, 1'b0, lat);
        chk("after_reset_latency", 512'(lat), 512'(R32 + 1));
        chk("after_reset_digest", {256'b0, sout32}, {256'b0, exp256});

        // SHA-512 "abc".
        load_abc(1);
        chk("model_abc512_w0", 512'(model_run(1)[511:448]), 512'(exp512_w0));
        run_block(1, 1'b0, lat);
        chk("abc512_latency", 512'(lat), 512'(R64 + 1));
        chk("abc512_word0", 512'(sout64[511:448]), 512'(exp512_w0));

        // Random initial hashes, schedule words and constants on both widths.
        for (int it = 0; it < 4; it++) begin
            for (int l = 0; l < 2; l++) begin
                load_random(l);
                run_block(l, 1'b0, lat);
                chk($sformatf("rand_latency[%0d]", l), 512'(lat), 512'((l != 0) ? R64 + 1 : R32 + 1));
                chk($sformatf("rand_digest[%0d]", l), lane_out(l), model_run(l));
            end
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
